// File: rtl/mips_run_ctrl.sv
// Run controller for a MIPS core under test: holds the core in reset,
// lets it run until halt or timeout, and folds every retired register
// write into a signature that is compared against a golden value.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   restart         pulse that re-arms a finished run
//   halt            core reports it has stopped
//   wb_en/addr/data register-file write port being observed
//   core_rst        reset driven into the core
//   running/done    run status
//   pass/timeout    run verdict
//   cycle_cnt       RUN cycles elapsed (saturating)
//   wb_cnt          retired register writes (saturating)
//   signature       rotate-xor digest of the write stream
module mips_run_ctrl #(
    parameter int                 DATA_W       = 32,
    parameter int                 CNT_W        = 16,
    parameter int                 RST_CYCLES   = 2,
    parameter int                 TIMEOUT      = 1024,
    parameter logic [DATA_W-1:0]  EXPECTED_SIG = '0,
    parameter int                 EXPECTED_WB  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              halt,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              core_rst,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  wb_cnt,
    output logic [DATA_W-1:0] signature
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] EXP_WB    = CNT_W'(EXPECTED_WB);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t            state, state_nx;
    logic [7:0]        hold_cnt, hold_nx;
    logic [CNT_W-1:0]  cyc_nx, wbc_nx, cyc_inc;
    logic [DATA_W-1:0] sig_nx;
    logic              done_nx, pass_nx, to_nx;
    logic              wr_ev, to_hit;

    // Counters stick at all-ones instead of wrapping.
    assign cyc_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + ONE;
    assign wr_ev   = wb_en && (wb_addr != 5'd0);
    assign to_hit  = (cyc_inc == TO_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            core_rst  <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
            wb_cnt    <= '0;
            signature <= '0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            core_rst  <= (state_nx != RUN);
            running   <= (state_nx == RUN);
            done      <= done_nx;
            pass      <= pass_nx;
            timeout   <= to_nx;
            cycle_cnt <= cyc_nx;
            wb_cnt    <= wbc_nx;
            signature <= sig_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            HOLD: if (hold_cnt == HOLD_LAST) state_nx = RUN;
            RUN:  if (halt || to_hit)        state_nx = DONE;
            DONE: if (restart)               state_nx = HOLD;
            default:                         state_nx = HOLD;
        endcase
    end

    always_comb begin
        hold_nx = hold_cnt;
        cyc_nx  = cycle_cnt;
        wbc_nx  = wb_cnt;
        sig_nx  = signature;
        done_nx = done;
        pass_nx = pass;
        to_nx   = timeout;
        unique case (state)
            HOLD: begin
                hold_nx = (state_nx == RUN) ? 8'd0 : hold_cnt + 8'd1;
            end
            RUN: begin
                cyc_nx = cyc_inc;
                if (wr_ev) begin
                    wbc_nx = (&wb_cnt) ? wb_cnt : wb_cnt + ONE;
                    sig_nx = {signature[DATA_W-2:0], signature[DATA_W-1]}
                             ^ wb_data ^ DATA_W'(wb_addr);
                end
                // Verdict uses the values including this edge's write;
                // halt takes priority over a coincident timeout.
                if (state_nx == DONE) begin
                    done_nx = 1'b1;
                    to_nx   = !halt;
                    pass_nx = halt && (sig_nx == EXPECTED_SIG)
                              && (wbc_nx == EXP_WB);
                end
            end
            DONE: begin
                if (restart) begin
                    hold_nx = '0;
                    cyc_nx  = '0;
                    wbc_nx  = '0;
                    sig_nx  = '0;
                    done_nx = 1'b0;
                    pass_nx = 1'b0;
                    to_nx   = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with a cycle-level reference model
// and hand-computed checkpoints.
module tb_mips_run_ctrl;

    localparam int          DW   = 32;
    localparam int          CW   = 16;
    localparam int          RC   = 3;
    localparam int          TO   = 16;
    localparam logic [31:0] ESIG = 32'h15;
    localparam int          EWB  = 1;
    localparam longint      MAXC = 65535;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          restart = 1'b0;
    logic          halt    = 1'b0;
    logic          wb_en   = 1'b0;
    logic [4:0]    wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          core_rst, running, done, pass, timeout;
    logic [CW-1:0] cycle_cnt, wb_cnt;
    logic [DW-1:0] signature;

    mips_run_ctrl #(
        .DATA_W(DW), .CNT_W(CW), .RST_CYCLES(RC), .TIMEOUT(TO),
        .EXPECTED_SIG(ESIG), .EXPECTED_WB(EWB)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .halt(halt),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .core_rst(core_rst), .running(running), .done(done),
        .pass(pass), .timeout(timeout), .cycle_cnt(cycle_cnt),
        .wb_cnt(wb_cnt), .signature(signature)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: phase 0=hold, 1=run, 2=done.
    int          m_phase = 0;
    int          m_hold  = 0;
    longint      m_cyc   = 0;
    longint      m_wb    = 0;
    logic [31:0] m_sig   = '0;
    bit          m_done  = 0;
    bit          m_pass  = 0;
    bit          m_to    = 0;

    task automatic model_reset();
        m_phase = 0; m_hold = 0; m_cyc = 0; m_wb = 0;
        m_sig = '0; m_done = 0; m_pass = 0; m_to = 0;
    endtask

    task automatic model_edge();
        if (m_phase == 0) begin
            m_hold++;
            if (m_hold == RC) begin
                m_phase = 1;
                m_hold  = 0;
            end
        end else if (m_phase == 1) begin
            if (m_cyc < MAXC) m_cyc++;
            if (wb_en && wb_addr != 0) begin
                if (m_wb < MAXC) m_wb++;
                m_sig = ((m_sig << 1) | (m_sig >> 31))
                        ^ wb_data ^ {27'd0, wb_addr};
            end
            if (halt || m_cyc == TO) begin
                m_phase = 2;
                m_done  = 1;
                m_to    = !halt;
                m_pass  = !m_to && m_sig == ESIG && m_wb == EWB;
            end
        end else if (restart) begin
            model_reset();
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_edge();
        #1;
        if (!rst) begin
            chk("m_core_rst", core_rst, (m_phase != 1));
            chk("m_running",  running,  (m_phase == 1));
            chk("m_done",     done,     m_done);
            chk("m_pass",     pass,     m_pass);
            chk("m_timeout",  timeout,  m_to);
            chk("m_cycle",    cycle_cnt, m_cyc);
            chk("m_wb",       wb_cnt,   m_wb);
            chk("m_sig",      signature, m_sig);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic hold_to_run();
        step(); step();
        chk("hold_core_rst", core_rst, 1);
        step();
        chk("run_entry", running, 1);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_core_rst", core_rst, 1);
        chk("rst_running",  running,  0);
        chk("rst_done",     done,     0);
        chk("rst_sig",      signature, 0);
        chk("rst_cycle",    cycle_cnt, 0);
        rst = 1'b0;
        step();
        chk("hold_e1", core_rst, 1);
        step();
        chk("hold_e2", core_rst, 1);
        step();
        chk("hold_e3_core_rst", core_rst, 0);
        chk("hold_e3_running",  running,  1);
        chk("run_cyc0", cycle_cnt, 0);
        step();
        chk("run_cyc1", cycle_cnt, 1);
        step();
        chk("run_cyc2", cycle_cnt, 2);

        wb_en = 1; wb_addr = 5; wb_data = 32'h10;
        step();
        chk("sig_w1", signature, 32'h15);
        chk("wb_w1",  wb_cnt, 1);
        wb_addr = 2; wb_data = 32'h1;
        step();
        chk("sig_w2", signature, 32'h29);
        chk("wb_w2",  wb_cnt, 2);
        wb_addr = 0; wb_data = 32'hFFFF; restart = 1;
        step();
        chk("sig_r0", signature, 32'h29);
        chk("wb_r0",  wb_cnt, 2);
        chk("restart_in_run", running, 1);
        wb_en = 0; restart = 0;

        for (int i = 0; i < 30 && !done; i++) step();
        chk("to_done",    done,    1);
        chk("to_timeout", timeout, 1);
        chk("to_pass",    pass,    0);
        chk("to_cycle",   cycle_cnt, 16);
        chk("to_running", running, 0);
        halt = 1; wb_en = 1; wb_addr = 3; wb_data = 32'h7;
        step(); step();
        chk("frozen_sig", signature, 32'h29);
        chk("frozen_wb",  wb_cnt, 2);
        halt = 0; wb_en = 0;

        restart = 1;
        step();
        restart = 0;
        chk("rs_done",  done, 0);
        chk("rs_sig",   signature, 0);
        chk("rs_cycle", cycle_cnt, 0);
        chk("rs_core_rst", core_rst, 1);
        halt = 1;
        hold_to_run();
        halt = 0;
        step(); step();
        wb_en = 1; wb_addr = 5; wb_data = 32'h10; halt = 1;
        step();
        wb_en = 0; halt = 0;
        chk("halt_done",    done, 1);
        chk("halt_pass",    pass, 1);
        chk("halt_wb",      wb_cnt, 1);
        chk("halt_timeout", timeout, 0);
        chk("halt_sig",     signature, 32'h15);

        restart = 1;
        step();
        restart = 0;
        hold_to_run();
        for (int i = 0; i < 20 && cycle_cnt != 15; i++) step();
        halt = 1;
        step();
        halt = 0;
        chk("tie_done",    done, 1);
        chk("tie_timeout", timeout, 0);
        chk("tie_cycle",   cycle_cnt, 16);
        chk("tie_pass",    pass, 0);

        restart = 1;
        step();
        restart = 0;
        hold_to_run();
        repeat (7) step();
        chk("mid_cyc7", cycle_cnt, 7);
        #2 rst = 1;
        #1;
        chk("async_core_rst", core_rst, 1);
        chk("async_running",  running, 0);
        chk("async_cycle",    cycle_cnt, 0);
        @(negedge clk);
        rst = 0;
        hold_to_run();
        step();
        chk("rerun_cyc1", cycle_cnt, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
